// File: rtl/param_fifo_pkg.sv
// Shared types and helpers for the param_fifo buffering stage.
package param_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_e;

  // Pointer width; a single-entry FIFO still carries a 1-bit pointer.
  function automatic int ptr_width(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_fifo_ctrl.sv
// Type-agnostic FIFO controller: read/write pointers, occupancy and state.
// Push/pop requests arrive already qualified by the top-level handshake,
// so one controller serves every element type specialisation.
module param_fifo_ctrl
  import param_fifo_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output fifo_state_e   state_o
);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "param_fifo_ctrl: DEPTH must be >= 1");
  end

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_state_e   state_q, state_d;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Next-state: flush wins, otherwise advance pointers and adjust occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (pop_i && !push_i) count_d = count_q - CW'(1);
    end
    if (count_d == '0)           state_d = EMPTY;
    else if (count_d == FULL_CNT) state_d = FULL;
    else                          state_d = PARTIAL;
  end

  // Control registers; state is registered alongside the count it encodes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign state_o  = state_q;

endmodule

// File: rtl/param_fifo.sv
// Type-parameterized synchronous FIFO with valid/ready on both sides.
// Holds the T-typed storage and output muxing; control lives in
// param_fifo_ctrl. Define PARAM_FIFO_BYPASS_EN to let data pass straight
// through an empty FIFO in the same cycle.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter type T     = bit,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  T              in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output T              out_data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = ptr_width(DEPTH);

  fifo_state_e   state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;

  // Storage is deliberately left out of reset.
  T mem_q [DEPTH];

  assign empty = (state == EMPTY);

`ifdef PARAM_FIFO_BYPASS_EN
  assign byp = empty && in_valid_i && !flush_i;
`else
  assign byp = 1'b0;
`endif

  // Ready depends only on registered state: no combinational ready path.
  assign in_ready_o  = (state != FULL);
  assign out_valid_o = !empty || byp;

  // A bypassed element that is consumed immediately is never stored.
  assign push = in_valid_i && in_ready_o && !flush_i && !(byp && out_ready_i);
  assign pop  = !empty && out_ready_i && !flush_i;

  param_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count_o),
    .state_o  (state)
  );

  // Write accepted elements into storage.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= in_data_i;
  end

  // Head element, bypass data, or zero when nothing is available.
  always_comb begin
    out_data_o = '0;
    if (byp)         out_data_o = in_data_i;
    else if (!empty) out_data_o = mem_q[rd_ptr];
  end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed scenarios on several specialisations plus a
// randomized run checked against a queue-based reference model.
module tb_param_fifo;

`ifdef PARAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // dut_a: default #() -> bit, depth 4
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  bit a_in_data = 0, a_out_data;
  logic [2:0] a_count;
  // dut_b: logic [7:0], depth 3
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [1:0] b_count;
  // dut_c: logic [7:0], depth 2
  logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [1:0] c_count;
  // dut_d: logic [3:0], depth 4
  logic d_flush = 0, d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
  logic [3:0] d_in_data = 0, d_out_data;
  logic [2:0] d_count;

  param_fifo dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count));

  param_fifo #(.T(logic [7:0]), .DEPTH(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count));

  param_fifo #(.T(logic [7:0]), .DEPTH(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .count_o(c_count));

  param_fifo #(.T(logic [3:0]), .DEPTH(4)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .in_data_i(d_in_data),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready), .out_data_o(d_out_data),
    .count_o(d_count));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_a_in_ready got %b want 1", a_in_ready); end
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_a_out_valid got %b want 0", a_out_valid); end
    vectors++; if (a_out_data !== 1'b0) begin miscompares++; $display("FAIL rst_a_out_data got %b want 0", a_out_data); end
    vectors++; if (a_count !== 3'd0) begin miscompares++; $display("FAIL rst_a_count got %0d want 0", a_count); end
    vectors++; if (b_out_data !== 8'h00) begin miscompares++; $display("FAIL rst_b_out_data got %h want 00", b_out_data); end
    vectors++; if (c_count !== 2'd0) begin miscompares++; $display("FAIL rst_c_count got %0d want 0", c_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d] got %b want 1", i, a_in_ready); end
      a_in_valid = 1'b1; a_in_data = pat[i];
    end
    @(negedge clk);
    a_in_data = 1'b0;
    vectors++; if (a_count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d want 4", a_count); end
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b want 0", a_in_ready); end
    @(negedge clk);
    vectors++; if (a_count !== 3'd4) begin miscompares++; $display("FAIL stall_count got %0d want 4", a_count); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b want 1", i, a_out_valid); end
      vectors++; if (a_out_data !== pat[i]) begin miscompares++; $display("FAIL drain_data[%0d] got %b want %b", i, a_out_data, pat[i]); end
      @(negedge clk);
    end
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL drained_valid got %b want 0", a_out_valid); end
    vectors++; if (a_out_data !== 1'b0) begin miscompares++; $display("FAIL drained_data got %b want 0", a_out_data); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp [3] = '{8'hA2, 8'hA3, 8'hA4};
    @(negedge clk); b_in_valid = 1'b1; b_in_data = 8'hA1;
    @(negedge clk); b_in_data = 8'hA2;
    @(negedge clk); b_in_valid = 1'b0; b_out_ready = 1'b1;
    vectors++; if (b_out_data !== 8'hA1) begin miscompares++; $display("FAIL wrap_first got %h want a1", b_out_data); end
    @(negedge clk); b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hA3;
    @(negedge clk); b_in_data = 8'hA4;
    @(negedge clk); b_in_valid = 1'b0;
    vectors++; if (b_count !== 2'd3) begin miscompares++; $display("FAIL wrap_count got %0d want 3", b_count); end
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (b_out_data !== exp[i]) begin miscompares++; $display("FAIL wrap_pop[%0d] got %h want %h", i, b_out_data, exp[i]); end
      @(negedge clk);
    end
    b_out_ready = 1'b0;
    vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b want 0", b_out_valid); end
  endtask

  task automatic test_full_traffic();
    @(negedge clk); c_in_valid = 1'b1; c_in_data = 8'h11;
    @(negedge clk); c_in_data = 8'h22;
    @(negedge clk); c_in_data = 8'h33; c_out_ready = 1'b1;
    #1;
    vectors++; if (c_in_ready !== 1'b0) begin miscompares++; $display("FAIL ft_ready_full got %b want 0", c_in_ready); end
    vectors++; if (c_out_data !== 8'h11) begin miscompares++; $display("FAIL ft_head got %h want 11", c_out_data); end
    @(negedge clk); c_out_ready = 1'b0;
    vectors++; if (c_count !== 2'd1) begin miscompares++; $display("FAIL ft_count1 got %0d want 1", c_count); end
    vectors++; if (c_in_ready !== 1'b1) begin miscompares++; $display("FAIL ft_ready_free got %b want 1", c_in_ready); end
    vectors++; if (c_out_data !== 8'h22) begin miscompares++; $display("FAIL ft_head2 got %h want 22", c_out_data); end
    @(negedge clk); c_in_valid = 1'b0;
    vectors++; if (c_count !== 2'd2) begin miscompares++; $display("FAIL ft_count2 got %0d want 2", c_count); end
    c_out_ready = 1'b1;
    #1;
    vectors++; if (c_out_data !== 8'h22) begin miscompares++; $display("FAIL ft_pop1 got %h want 22", c_out_data); end
    @(negedge clk);
    vectors++; if (c_out_data !== 8'h33) begin miscompares++; $display("FAIL ft_pop2 got %h want 33", c_out_data); end
    @(negedge clk); c_out_ready = 1'b0;
    vectors++; if (c_out_valid !== 1'b0) begin miscompares++; $display("FAIL ft_empty got %b want 0", c_out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); b_in_valid = 1'b1; b_in_data = 8'h44;
    @(negedge clk); b_in_data = 8'h55;
    @(negedge clk); b_in_data = 8'h66; b_flush = 1'b1;
    @(negedge clk); b_flush = 1'b0; b_in_valid = 1'b0;
    vectors++; if (b_count !== 2'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", b_count); end
    vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", b_out_valid); end
    vectors++; if (b_out_data !== 8'h00) begin miscompares++; $display("FAIL flush_data got %h want 00", b_out_data); end
    b_in_valid = 1'b1; b_in_data = 8'h77;
    @(negedge clk); b_in_valid = 1'b0;
    vectors++; if (b_count !== 2'd1) begin miscompares++; $display("FAIL flush_after_count got %0d want 1", b_count); end
    vectors++; if (b_out_data !== 8'h77) begin miscompares++; $display("FAIL flush_after_head got %h want 77", b_out_data); end
    b_out_ready = 1'b1;
    @(negedge clk); b_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); d_in_valid = 1'b1; d_in_data = 4'(i);
    end
    @(negedge clk); d_in_valid = 1'b0;
    vectors++; if (d_count !== 3'd3) begin miscompares++; $display("FAIL ar_pre_count got %0d want 3", d_count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (d_count !== 3'd0) begin miscompares++; $display("FAIL ar_count got %0d want 0", d_count); end
    vectors++; if (d_out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", d_out_valid); end
    vectors++; if (d_out_data !== 4'h0) begin miscompares++; $display("FAIL ar_data got %h want 0", d_out_data); end
    vectors++; if (d_in_ready !== 1'b1) begin miscompares++; $display("FAIL ar_ready got %b want 1", d_in_ready); end
    #1 rst_n = 1'b1;
    @(negedge clk); d_in_valid = 1'b1; d_in_data = 4'h5;
    @(negedge clk); d_in_valid = 1'b0;
    vectors++; if (d_out_valid !== 1'b1) begin miscompares++; $display("FAIL ar_push_valid got %b want 1", d_out_valid); end
    vectors++; if (d_out_data !== 4'h5) begin miscompares++; $display("FAIL ar_push_data got %h want 5", d_out_data); end
    vectors++; if (d_count !== 3'd1) begin miscompares++; $display("FAIL ar_push_count got %0d want 1", d_count); end
    d_out_ready = 1'b1;
    @(negedge clk); d_out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk); d_in_valid = 1'b1; d_in_data = 4'h9; d_out_ready = 1'b1;
    #1;
    vectors++; if (d_out_valid !== BYP) begin miscompares++; $display("FAIL byp_valid got %b want %b", d_out_valid, BYP); end
    vectors++; if (d_out_data !== (BYP ? 4'h9 : 4'h0)) begin miscompares++; $display("FAIL byp_data got %h want %h", d_out_data, BYP ? 4'h9 : 4'h0); end
    @(negedge clk); d_in_valid = 1'b0; d_out_ready = 1'b0;
    vectors++; if (d_count !== (BYP ? 3'd0 : 3'd1)) begin miscompares++; $display("FAIL byp_count got %0d want %0d", d_count, BYP ? 0 : 1); end
    if (!BYP) begin
      d_out_ready = 1'b1;
      @(negedge clk); d_out_ready = 1'b0;
    end
    d_in_valid = 1'b1; d_in_data = 4'h6; d_flush = 1'b1;
    #1;
    vectors++; if (d_out_valid !== 1'b0) begin miscompares++; $display("FAIL byp_flush_valid got %b want 0", d_out_valid); end
    @(negedge clk); d_in_valid = 1'b0; d_flush = 1'b0;
    vectors++; if (d_count !== 3'd0) begin miscompares++; $display("FAIL byp_flush_count got %0d want 0", d_count); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_data;
    logic exp_valid, exp_ready, bypass, stalled;
    stalled = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      b_flush = ($urandom_range(0, 19) == 0);
      b_out_ready = $urandom_range(0, 2) != 0;
      if (!stalled) begin
        b_in_valid = $urandom_range(0, 2) != 0;
        b_in_data = 8'($urandom);
      end
      #1;
      exp_ready = (q.size() < 3);
      bypass = BYP && (q.size() == 0) && b_in_valid && !b_flush;
      exp_valid = (q.size() != 0) || bypass;
      exp_data = bypass ? b_in_data : (q.size() != 0 ? q[0] : 8'h00);
      vectors++; if (b_in_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b want %b", n, b_in_ready, exp_ready); end
      vectors++; if (b_out_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", n, b_out_valid, exp_valid); end
      vectors++; if (b_out_data !== exp_data) begin miscompares++; $display("FAIL rnd_data[%0d] got %h want %h", n, b_out_data, exp_data); end
      vectors++; if (b_count !== 2'(q.size())) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, b_count, q.size()); end
      stalled = b_in_valid && !exp_ready && !b_flush;
      if (b_flush) begin
        q.delete();
      end else begin
        logic do_pop, do_push;
        do_pop = (q.size() != 0) && b_out_ready;
        do_push = b_in_valid && exp_ready && !(bypass && b_out_ready);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(b_in_data);
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_traffic();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
# param_fifo

Type-parameterized synchronous FIFO with a valid/ready handshake on both sides. It is the buffering stage placed directly upstream of parameterized leaf modules, e.g. modules with a `type T` port and a value-parameter output. It decouples a producer from such a consumer, and its own `#(type T, int DEPTH)` overrides exercise type and value parameter specialisation of a stateful block. One instance per specialisation; all width arithmetic derives from `$bits(T)` and `DEPTH`.

## Interface
Parameters:
- `T`, default `bit`: element type; any packed type, including `void`-free structs.
- `DEPTH`, default `4`: number of entries. Must be ≥1; elaboration `$fatal` otherwise. Need not be a power of two.

Ports:
- `clk_i`, input, 1: clock; all state on rising edge.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `flush_i`, input, 1: synchronous clear of all entries.
- `in_valid_i`, input, 1: producer has data.
- `in_ready_o`, output, 1: FIFO accepts data.
- `in_data_i`, input, `T`: write data.
- `out_valid_o`, output, 1: FIFO has data.
- `out_ready_i`, input, 1: consumer takes data.
- `out_data_o`, output, `T`: head element.
- `count_o`, output, `$clog2(DEPTH+1)`: current occupancy.

## Operation
- Push when `in_valid_i && in_ready_o`; pop when `out_valid_o && out_ready_i`.
- `in_ready_o = (state != FULL)`. It is registered-state-derived only and never depends on `out_ready_i`, so no combinational ready path.
- `out_valid_o = (state != EMPTY)`.
- `out_data_o = mem[rd_ptr]` when non-empty, `'0` when empty.
- States are derived from `count`:
  - EMPTY when count==0.
  - PARTIAL when 0<count<DEPTH.
  - FULL when count==DEPTH.
- Transitions:
  - push only: count+1.
  - pop only: count−1.
  - push+pop together: count unchanged, both pointers advance.
- Full + out_ready: pop only. Input stays not-ready that cycle; the freed slot is visible next cycle.
- Empty + in_valid: push only (non-bypass build). Data appears at the output next cycle.
- Pointers wrap from `DEPTH-1` to 0 by explicit compare, not modulo-2^n.
- DEPTH=1: state toggles EMPTY/FULL; pointers stay 0.
- `flush_i` has priority over push/pop:
  - next cycle count=0, pointers=0.
  - a simultaneous push is dropped.
  - storage contents are not cleared.
- Storage is not reset. Pointers and count are.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_data_o`='0, `count_o`=0.
- Reset asserted mid-operation clears state immediately (asynchronously). Contents are discarded.
- Latency push→`out_valid_o`: 1 cycle, or 0 with bypass.
- Throughput: 1 element/cycle sustained when PARTIAL.
- `count_o` updates on the edge following the handshake.
- Producer must hold `in_data_i` stable while `in_valid_i && !in_ready_o`. The FIFO holds `out_data_o` stable while `out_valid_o && !out_ready_i`.

## Configuration
- `PARAM_FIFO_BYPASS_EN` defined:
  - when EMPTY and `in_valid_i`, `out_valid_o`=1 and `out_data_o=in_data_i` combinationally.
  - if `out_ready_i` is also high, the element passes through without being stored; count stays 0.
  - `flush_i` suppresses bypass (`out_valid_o`=0 that cycle).
- Undefined: no bypass; minimum latency is 1 cycle, as above.

## Structure
- Package `param_fifo_pkg`:
  - `typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e`.
  - function `ptr_width(int depth)` returning `depth>1 ? $clog2(depth) : 1`.
- Sub-module `param_fifo_ctrl #(DEPTH)`: pointers, count, state, and the push/pop/flush decision. It is type-agnostic, so one controller serves all `T` specialisations.
- Top `param_fifo` holds the `T`-typed storage array and the data muxing (including bypass).

## Test plan
- Default `#()`, fill, drain:
  - push 1,0,1,1 → `count_o`=4, `in_ready_o`=0.
  - 5th push is stalled.
  - drain yields 1,0,1,1 in order; then `out_valid_o`=0, `out_data_o`=0.
- `#(logic [7:0], 3)` wrap-around:
  - push 0xA1,0xA2, pop one, push 0xA3,0xA4 (write pointer wraps).
  - pops give 0xA2,0xA3,0xA4.
- Full with simultaneous traffic, `#(logic [7:0], 2)`, full with 0x11,0x22:
  - assert in_valid (0x33) and out_ready in the same cycle → 0x11 popped, 0x33 not accepted.
  - next cycle 0x33 is accepted; `count_o`=2.
- Flush + push together at count=2 → next cycle `count_o`=0, `out_valid_o`=0, pushed value absent.
- Async reset pulse mid-stream at count=3:
  - outputs go to reset values before the next clock edge.
  - after release, a push of 0x5 reappears after 1 cycle.
- Bypass (macro defined), `#(logic [3:0])`, empty FIFO:
  - in_valid=1, data=0x9, out_ready=1 → same cycle `out_valid_o`=1, `out_data_o`=0x9.
  - `count_o` stays 0.
